// File: rtl/bin_to_bcd_display_pkg.sv
// Shared constants for the binary-to-BCD display feeder: FSM encoding,
// scratch depth and display saturation values.
package bin_to_bcd_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam int          BCD_DIGITS     = 5;
    localparam int          DISPLAY_DIGITS = 4;
    localparam logic [31:0] MAX_DISPLAY    = 32'd9999;
    localparam bcd_digit_t  SAT_DIGIT      = 4'd9;

endpackage

// File: rtl/bin_to_bcd_display_bcd_add3.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more
// so the following left shift carries correctly into the next decade.
module bcd_add3
    import bin_to_bcd_display_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential shift-add-3 converter: one binary bit per clock, result held on
// four registered BCD digits for the seven-segment driver.
module bin_to_bcd_display
    import bin_to_bcd_display_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       digit3,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = 4 * BCD_DIGITS;

    logic [1:0]       state;
    logic [WIDTH-1:0] bin_sr;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] scratch_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_pending;
    logic             ovf_final;

    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic sat);
        return sat ? SAT_DIGIT : d;
    endfunction

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*i +: 4]),
            .dout (scratch_adj[4*i +: 4])
        );
    end

    // The fifth decade is nonzero only above 9999, so it backs up the capture-time compare.
    assign ovf_final = ovf_pending | (scratch[SCR_W-1 -: 4] != 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bin_sr      <= '0;
            scratch     <= '0;
            bit_cnt     <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            digit3      <= 4'd0;
            digit2      <= 4'd0;
            digit1      <= 4'd0;
            digit0      <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr      <= value;
                        scratch     <= '0;
                        bit_cnt     <= '0;
                        ovf_pending <= (32'(value) > MAX_DISPLAY);
                        busy        <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {scratch, bin_sr} <= {scratch_adj[SCR_W-2:0], bin_sr, 1'b0};
                    bit_cnt           <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    digit3   <= sat_digit(scratch[15:12], ovf_final);
                    digit2   <= sat_digit(scratch[11:8],  ovf_final);
                    digit1   <= sat_digit(scratch[7:4],   ovf_final);
                    digit0   <= sat_digit(scratch[3:0],   ovf_final);
                    overflow <= ovf_final;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Scoreboard bench for bin_to_bcd_display: stimulus pushes expected digits,
// a negedge monitor pops and compares whenever done pulses.
module tb_bin_to_bcd_display;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       ovf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] value;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic        busy, done, overflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    bin_to_bcd_display #(.WIDTH(14)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .digit3   (digit3),
        .digit2   (digit2),
        .digit1   (digit1),
        .digit0   (digit0),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int d3, input int d2, input int d1, input int d0, input int ovf);
        exp_t e;
        e.d3  = 4'(d3);
        e.d2  = 4'(d2);
        e.d1  = 4'(d1);
        e.d0  = 4'(d0);
        e.ovf = 1'(ovf);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: digits %0d%0d%0d%0d with no conversion outstanding",
                         digit3, digit2, digit1, digit0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("digits_ovf", 32'({digit3, digit2, digit1, digit0, overflow}), 32'(e));
            end
        end
    end

    task automatic wait_done();
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("done_within_budget", 32'(found), 32'd1);
    endtask

    task automatic run_conv(input logic [13:0] v, input exp_t e, input bit midcheck, input exp_t prev);
        @(posedge clock); #1;
        value = v;
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
        if (midcheck) begin
            repeat (5) @(negedge clock);
            check("digits_held_mid_conv", 32'({digit3, digit2, digit1, digit0, overflow}), 32'(prev));
        end
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int cnt;
        exp_t nxt [3];
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 32'({digit3, digit2, digit1, digit0, busy, done, overflow}), 32'd0);
        reset = 1'b0;

        // 1234: busy length, done timing, digits
        @(posedge clock); #1;
        value = 14'd1234;
        start = 1'b1;
        sb_q.push_back(mk(1, 2, 3, 4, 0));
        @(posedge clock); #1;
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            else break;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd15);
        check("done_after_busy", 32'(done), 32'd1);

        // Zero, full-scale, overflow saturation and recovery
        run_conv(14'd0,     mk(0, 0, 0, 0, 0), 1'b0, mk(0, 0, 0, 0, 0));
        run_conv(14'd9999,  mk(9, 9, 9, 9, 0), 1'b1, mk(0, 0, 0, 0, 0));
        run_conv(14'd10000, mk(9, 9, 9, 9, 1), 1'b1, mk(9, 9, 9, 9, 0));
        run_conv(14'd16383, mk(9, 9, 9, 9, 1), 1'b0, mk(0, 0, 0, 0, 0));
        run_conv(14'd42,    mk(0, 0, 4, 2, 0), 1'b1, mk(9, 9, 9, 9, 1));

        // Start ignored while busy (E5 and the FINISH cycle)
        @(posedge clock); #1;
        value = 14'd5678;
        start = 1'b1;
        sb_q.push_back(mk(5, 6, 7, 8, 0));
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        value = 14'd1111;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clock);
        check("no_second_conversion_busy", 32'(busy), 32'd0);

        // Start held high: back-to-back, value perturbed mid-conversion
        nxt[0] = mk(0, 3, 2, 2, 0);
        nxt[1] = mk(0, 3, 2, 3, 0);
        nxt[2] = mk(0, 3, 2, 4, 0);
        @(posedge clock); #1;
        value = 14'd321;
        start = 1'b1;
        sb_q.push_back(mk(0, 3, 2, 1, 0));
        for (int k = 0; k < 4; k++) begin
            bit found = 1'b0;
            cnt = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                cnt++;
                if (cnt == 5) value = 14'd7777;
                if (done === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            check("stream_done_seen", 32'(found), 32'd1);
            if (k > 0) check("stream_period", 32'(cnt), 32'd16);
            if (k < 3) begin
                value = 14'(322 + k);
                sb_q.push_back(nxt[k]);
            end else begin
                start = 1'b0;
            end
        end

        // Asynchronous reset at E7 of a 4321 conversion
        @(posedge clock); #1;
        value = 14'd4321;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_outputs_cleared", 32'({digit3, digit2, digit1, digit0, busy, done, overflow}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_no_resume", 32'(busy), 32'd0);
        run_conv(14'd8765, mk(8, 7, 6, 5, 0), 1'b0, mk(0, 0, 0, 0, 0));

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
